// File: rtl/tinker_mem_arbiter_if.sv
// Requester and memory bus bundle for tinker_mem_arbiter.
// The master view is the arbiter's. The slave view is for the environment.
interface tinker_mem_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_gnt;
  logic              i_rvalid;
  logic [63:0]       i_rdata;
  logic              i_err;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [63:0]       d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [63:0]       d_rdata;
  logic              d_err;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [63:0]       mem_wdata;
  logic              mem_rvalid;
  logic [63:0]       mem_rdata;

  modport master (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rvalid, mem_rdata,
    output i_gnt, i_rvalid, i_rdata, i_err, d_gnt, d_rvalid, d_rdata, d_err,
           mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rvalid, mem_rdata,
    input  i_gnt, i_rvalid, i_rdata, i_err, d_gnt, d_rvalid, d_rdata, d_err,
           mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/tinker_mem_arbiter.sv
// Round-robin arbiter sharing the single 64-bit memory port between fetch and data.
// One transaction in flight; it checks alignment and times out reads that get no response.
module tinker_mem_arbiter #(
  parameter int TIMEOUT = 255,
  parameter int ADDR_W  = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 hlt,
  tinker_mem_arbiter_if.master bus
);

  // state | meaning
  // IDLE  | arbitrate, grant combinationally, capture request
  // ISSUE | drive one memory strobe
  // WAIT  | wait for mem_rvalid or timeout
  // RESP  | one-cycle response to the captured requester
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  localparam logic       ID_FETCH = 1'b0;
  localparam logic       ID_DATA  = 1'b1;
  localparam logic [7:0] TO_CNT   = 8'(TIMEOUT);

  state_e            state_q, state_d;
  logic              rr_last_q, rr_last_d;
  logic              id_q, id_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [63:0]       wdata_q, wdata_d;
  logic [63:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [7:0]        cnt_q, cnt_d;

  logic ireq_e, dreq_e, win_data, misalign;
  logic [7:0] cnt_inc;
  logic i_gnt, d_gnt, i_rvalid, d_rvalid, mem_req;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      rr_last_q <= ID_DATA;
      id_q      <= ID_FETCH;
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      rr_last_q <= rr_last_d;
      id_q      <= id_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_last_d = rr_last_q;
    id_d      = id_q;
    addr_d    = addr_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    i_gnt     = 1'b0;
    d_gnt     = 1'b0;
    i_rvalid  = 1'b0;
    d_rvalid  = 1'b0;
    mem_req   = 1'b0;
    misalign  = 1'b0;
    cnt_inc   = cnt_q + 8'd1;
    ireq_e    = bus.i_req & ~hlt;
    dreq_e    = bus.d_req;
    // On a tie the requester that did not win last time goes next.
    win_data  = dreq_e & (~ireq_e | (rr_last_q == ID_FETCH));

    unique case (state_q)
      IDLE: begin
        if (!reset && (ireq_e || dreq_e)) begin
          i_gnt     = ~win_data;
          d_gnt     = win_data;
          id_d      = win_data;
          rr_last_d = win_data;
          cnt_d     = '0;
          if (win_data) begin
            addr_d   = bus.d_addr;
            we_d     = bus.d_we;
            wdata_d  = bus.d_wdata;
            misalign = |bus.d_addr[2:0];
          end else begin
            addr_d   = bus.i_addr;
            we_d     = 1'b0;
            wdata_d  = '0;
            misalign = |bus.i_addr[1:0];
          end
          if (misalign) begin
            err_d   = 1'b1;
            rdata_d = '0;
            state_d = RESP;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        mem_req = 1'b1;
        if (we_q) begin
          err_d   = 1'b0;
          rdata_d = '0;
          state_d = RESP;
        end else begin
          cnt_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (bus.mem_rvalid) begin
          rdata_d = bus.mem_rdata;
          err_d   = 1'b0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == TO_CNT) begin
            rdata_d = '0;
            err_d   = 1'b1;
            state_d = RESP;
          end
        end
      end
      RESP: begin
        i_rvalid = (id_q == ID_FETCH);
        d_rvalid = (id_q == ID_DATA);
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.i_gnt     = i_gnt;
  assign bus.d_gnt     = d_gnt;
  assign bus.i_rvalid  = i_rvalid;
  assign bus.d_rvalid  = d_rvalid;
  assign bus.i_rdata   = i_rvalid ? rdata_q : '0;
  assign bus.d_rdata   = d_rvalid ? rdata_q : '0;
  assign bus.i_err     = i_rvalid & err_q;
  assign bus.d_err     = d_rvalid & err_q;
  assign bus.mem_req   = mem_req;
  assign bus.mem_we    = mem_req & we_q;
  assign bus.mem_addr  = mem_req ? addr_q : '0;
  assign bus.mem_wdata = mem_req ? wdata_q : '0;

endmodule

// File: tb/tb_tinker_mem_arbiter.sv
// Directed bench for tinker_mem_arbiter: a transaction-timeline model predicts every
// output each cycle, and literal checks pin the model's timing and data.
module tb_tinker_mem_arbiter;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic hlt = 1'b0;

  tinker_mem_arbiter_if #(.ADDR_W(32)) bus();

  tinker_mem_arbiter #(.TIMEOUT(TO), .ADDR_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .hlt   (hlt),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int n_vec = 0;
  int n_bad = 0;
  int mem_lat = 1;
  logic [63:0] mem_word = 64'h0;

  // Model: the whole transaction is laid out on a cycle timeline at grant time.
  int          free_cyc = 0;
  logic        rr_last = 1'b1;
  int          em_cyc = -1;
  logic        em_we = 1'b0;
  logic [31:0] em_addr = '0;
  logic [63:0] em_wdata = '0;
  int          er_cyc = -1;
  logic        er_id = 1'b0;
  logic [63:0] er_data = '0;
  logic        er_err = 1'b0;
  int          g_cyc[$];
  logic        g_id[$];

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  initial begin : compare
    logic ie, de, wd, mis, we;
    logic [31:0] a;
    logic [63:0] wdv;
    logic [127:0] e;
    forever begin
      @(negedge clk);
      if (reset) begin
        free_cyc = cyc + 1;
        rr_last  = 1'b1;
        em_cyc   = -1;
        er_cyc   = -1;
      end else begin
        ie = 1'b0;
        de = 1'b0;
        wd = 1'b0;
        if (cyc >= free_cyc) begin
          ie = bus.i_req & ~hlt;
          de = bus.d_req;
          if (ie | de) begin
            wd = de & (~ie | (rr_last == 1'b0));
            rr_last = wd;
            g_cyc.push_back(cyc);
            g_id.push_back(wd);
            if (wd) begin
              a = bus.d_addr; we = bus.d_we; wdv = bus.d_wdata; mis = (a % 8) != 0;
            end else begin
              a = bus.i_addr; we = 1'b0; wdv = 64'h0; mis = (a % 4) != 0;
            end
            er_id = wd;
            if (mis) begin
              er_cyc = cyc + 1; er_data = 64'h0; er_err = 1'b1;
            end else begin
              em_cyc = cyc + 1; em_we = we; em_addr = a; em_wdata = wdv;
              if (we) begin
                er_cyc = cyc + 2; er_data = 64'h0; er_err = 1'b0;
              end else if (mem_lat >= 1 && mem_lat <= TO) begin
                er_cyc = cyc + 2 + mem_lat; er_data = mem_word; er_err = 1'b0;
              end else begin
                er_cyc = cyc + 2 + TO; er_data = 64'h0; er_err = 1'b1;
              end
            end
            free_cyc = er_cyc + 1;
          end
        end
        chk("gnt", {126'h0, bus.i_gnt, bus.d_gnt}, {126'h0, (ie | de) & ~wd, (ie | de) & wd});
        e = '0;
        if (cyc == em_cyc) e = {30'h0, 1'b1, em_we, em_addr, em_wdata};
        chk("mem", {30'h0, bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata}, e);
        e = '0;
        if (cyc == er_cyc && er_id == 1'b0) e = {62'h0, 1'b1, er_err, er_data};
        chk("i_rsp", {62'h0, bus.i_rvalid, bus.i_err, bus.i_rdata}, e);
        e = '0;
        if (cyc == er_cyc && er_id == 1'b1) e = {62'h0, 1'b1, er_err, er_data};
        chk("d_rsp", {62'h0, bus.d_rvalid, bus.d_err, bus.d_rdata}, e);
      end
    end
  end

  // Memory: answers mem_req after mem_lat cycles; mem_lat of 0 never answers.
  initial begin : memory
    int pend;
    logic [63:0] pdata;
    pend = -1;
    pdata = '0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.mem_rvalid = (cyc == pend);
      bus.mem_rdata  = (cyc == pend) ? pdata : 64'h0;
      @(negedge clk);
      if (reset) pend = -1;
      else if (bus.mem_req && mem_lat > 0) begin
        pend  = cyc + mem_lat;
        pdata = mem_word;
      end
    end
  end

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_gnt(input bit want_d, output int gc);
    gc = -1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (want_d ? bus.d_gnt : bus.i_gnt) begin
        gc = cyc;
        return;
      end
    end
    gc = cyc;
    n_vec++;
    n_bad++;
    $display("FAIL wait_gnt(%0d) timed out at cycle %0d: got no grant, required grant within 50", want_d, cyc);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  task automatic summary();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
  endtask

  initial begin : watchdog
    #200000;
    n_bad++;
    $display("FAIL watchdog at cycle %0d: got no finish, required finish", cyc);
    summary();
    $finish;
  end

  initial begin : stim
    int gc, ig_cnt, dg_cnt;
    bus.i_req = 1'b0; bus.i_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    tick(2);
    reset = 1'b0;

    // Fetch with one-cycle memory latency.
    mem_lat = 1; mem_word = 64'h13;
    bus.i_addr = 32'h2000; bus.i_req = 1'b1;
    wait_gnt(1'b0, gc);
    tick(); bus.i_req = 1'b0;
    tick(5);
    chk("t1_mem_cycle", em_cyc - gc, 1);
    chk("t1_mem_addr", em_addr, 32'h2000);
    chk("t1_rsp_cycle", er_cyc - gc, 3);
    chk("t1_rsp_data", er_data, 64'h13);

    // Both requesting continuously: fetch first, then strict alternation.
    do_reset();
    g_cyc.delete(); g_id.delete();
    mem_word = 64'hABCD;
    bus.i_addr = 32'h100; bus.i_req = 1'b1;
    bus.d_addr = 32'h200; bus.d_we = 1'b0; bus.d_req = 1'b1;
    tick(14);
    bus.i_req = 1'b0; bus.d_req = 1'b0;
    tick(6);
    chk("t2_ngrants", g_id.size(), 4);
    if (g_id.size() >= 4) begin
      chk("t2_order", {g_id[0], g_id[1], g_id[2], g_id[3]}, 4'b0101);
      chk("t2_gap", g_cyc[3] - g_cyc[0], 12);
    end

    // Store.
    bus.d_addr = 32'h80000; bus.d_we = 1'b1; bus.d_wdata = 64'hDEADBEEF; bus.d_req = 1'b1;
    wait_gnt(1'b1, gc);
    tick(); bus.d_req = 1'b0; bus.d_we = 1'b0;
    tick(4);
    chk("t3_mem", {em_cyc - gc, em_we, em_addr, em_wdata}, {32'd1, 1'b1, 32'h80000, 64'hDEADBEEF});
    chk("t3_rsp", {er_cyc - gc, er_err}, {32'd2, 1'b0});

    // Misaligned data load and misaligned fetch.
    bus.d_addr = 32'h80004; bus.d_req = 1'b1;
    wait_gnt(1'b1, gc);
    tick(); bus.d_req = 1'b0;
    tick(3);
    chk("t4_d_rsp", {er_cyc - gc, er_err, er_data}, {32'd1, 1'b1, 64'h0});
    chk("t4_d_nomem", em_cyc < gc, 1);
    bus.i_addr = 32'h2002; bus.i_req = 1'b1;
    wait_gnt(1'b0, gc);
    tick(); bus.i_req = 1'b0;
    tick(3);
    chk("t4_i_rsp", {er_cyc - gc, er_id, er_err}, {32'd1, 1'b0, 1'b1});

    // Lost read response times out, late response is ignored.
    mem_lat = 6; mem_word = 64'h5555;
    bus.d_addr = 32'h300; bus.d_req = 1'b1;
    wait_gnt(1'b1, gc);
    tick(); bus.d_req = 1'b0;
    tick(10);
    chk("t5_timeout", {er_cyc - gc, er_err, er_data}, {32'd6, 1'b1, 64'h0});
    mem_lat = 1;

    // Halt masks fetch grants; data still served.
    hlt = 1'b1;
    bus.i_addr = 32'h400; bus.i_req = 1'b1;
    bus.d_addr = 32'h500; bus.d_req = 1'b1;
    ig_cnt = 0; dg_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      ig_cnt += int'(bus.i_gnt);
      dg_cnt += int'(bus.d_gnt);
    end
    chk("t6_hlt_i_gnt", ig_cnt, 0);
    chk("t6_hlt_d_gnt", dg_cnt, 3);
    tick(); bus.d_req = 1'b0;
    tick(5);
    // Halt rising during a fetch still lets its response through.
    hlt = 1'b0;
    mem_word = 64'h4242;
    wait_gnt(1'b0, gc);
    tick(); bus.i_req = 1'b0; hlt = 1'b1;
    tick(5);
    chk("t6_inflight", {er_cyc - gc, er_id, er_data}, {32'd3, 1'b0, 64'h4242});
    hlt = 1'b0;

    // Reset during WAIT aborts silently; next request is served normally.
    mem_lat = 0;
    bus.d_addr = 32'h600; bus.d_we = 1'b0; bus.d_req = 1'b1;
    wait_gnt(1'b1, gc);
    tick(); bus.d_req = 1'b0;
    tick(2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick(3);
    mem_lat = 1; mem_word = 64'h77;
    bus.i_addr = 32'h700; bus.i_req = 1'b1;
    wait_gnt(1'b0, gc);
    tick(); bus.i_req = 1'b0;
    tick(5);
    chk("t7_after_reset", {er_cyc - gc, er_id, er_err, er_data}, {32'd3, 1'b0, 1'b0, 64'h77});

    summary();
    $finish;
  end
endmodule
